branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged target table with per-entry saturating
// direction counters, combinational lookup and redirect, one-cycle training.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       correct_pc,
    input  logic              clear,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];
    logic [STAT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, upd_hit;

    // Word-aligned PCs: the two low bits never select or tag an entry.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                      (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    always_comb begin
        // NOTE: every _d signal takes its _q value first so no path leaves it unassigned (no latch).
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        ctr_d      = ctr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        if (clear) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (mispredict) begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end else begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end

            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != '1) ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
                    target_d[upd_idx] = upd_target;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = CTR_WEAK_T;
            end
        end
    end

    // NOTE: the table is a flop array, so reset clears every entry; a RAM macro could not offer this.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table, directed corner
// sequences and randomized traffic against an array-based reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int STAT_W  = 16;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_target;
    logic              mispredict;
    logic [31:0]       correct_pc;
    logic              clear;
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;

    branch_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .correct_pc(correct_pc), .clear(clear),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_hits, m_miss;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = CTR_HALF - 1;
        end
        m_hits = 0; m_miss = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
        t   = model_hit(pc) && (m_ctr[midx(pc)] >= CTR_HALF);
        tgt = t ? m_tgt[midx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit model_misp(input bit v, input bit t, input logic [31:0] tgt,
                                      input bit pt, input logic [31:0] ptgt);
        return v && ((t != pt) || (t && tgt != ptgt));
    endfunction

    function automatic void model_update(input bit clr, input bit v, input logic [31:0] pc,
                                         input bit t, input logic [31:0] tgt,
                                         input bit pt, input logic [31:0] ptgt);
        int i;
        if (clr) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
            return;
        end
        if (!v) return;
        if (model_misp(v, t, tgt, pt, ptgt)) m_miss = (m_miss < STAT_MAX) ? m_miss + 1 : m_miss;
        else                                 m_hits = (m_hits < STAT_MAX) ? m_hits + 1 : m_hits;
        i = midx(pc);
        if (model_hit(pc)) begin
            if (t) begin
                m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (t) begin
            m_valid[i] = 1; m_tag[i] = mtag(pc); m_tgt[i] = tgt; m_ctr[i] = CTR_HALF;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                           input bit pt, input logic [31:0] ptgt);
        upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
        upd_pred_taken = pt; upd_pred_target = ptgt;
    endtask

    task automatic idle();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        cyc();
    endtask

    task automatic look(input string name, input logic [31:0] pc, input bit exp_t, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({name, ".pred_taken"}, 32'(pred_taken), 32'(exp_t));
        check({name, ".pred_target"}, pred_target, exp_tgt);
    endtask

    task automatic stats(input string name, input int exp_hit, input int exp_miss);
        check({name, ".hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
        check({name, ".miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          taken;
        logic [31:0] target;
        bit          ptaken;
        logic [31:0] ptarget;
        bit          exp_misp;
        logic [31:0] exp_cpc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        reset = 1'b1;
        if_pc = 32'h0;
        idle();

        vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0200};
        vecs[1] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200};
        vecs[2] = '{32'h0000_0100, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0104};
        vecs[3] = '{32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0104, 1'b0, 32'h0000_0104};
        vecs[4] = '{32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_dead, 1'b0, 32'h0000_0104};
        vecs[5] = '{32'hffff_fffc, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0000};
        vecs[6] = '{32'h0000_0300, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0300};

        // Reset state
        do_reset();
        look("rst", 32'h0040_0010, 1'b0, 32'h0040_0014);
        stats("rst", 0, 0);
        look("rst_wrap", 32'hffff_fffc, 1'b0, 32'h0000_0000);

        // Redirect vector table (combinational; table contents are reset afterwards)
        foreach (vecs[i]) begin
            set_upd(1'b1, vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].ptaken, vecs[i].ptarget);
            #1;
            check($sformatf("vec%0d.mispredict", i), 32'(mispredict), 32'(vecs[i].exp_misp));
            if (vecs[i].exp_misp) check($sformatf("vec%0d.correct_pc", i), correct_pc, vecs[i].exp_cpc);
            cyc();
        end

        // First taken branch allocates; following lookup predicts it
        do_reset();
        set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        #1;
        check("alloc.mispredict", 32'(mispredict), 32'd1);
        check("alloc.correct_pc", correct_pc, 32'h0040_0040);
        cyc();
        idle();
        stats("alloc", 0, 1);
        look("alloc", 32'h0040_0010, 1'b1, 32'h0040_0040);

        // Four not-taken updates saturate the counter at zero
        for (int k = 1; k <= 4; k++) begin
            set_upd(1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
            #1;
            check($sformatf("nt%0d.mispredict", k), 32'(mispredict), 32'd0);
            cyc();
            idle();
            stats($sformatf("nt%0d", k), k, 1);
            look($sformatf("nt%0d", k), 32'h0040_0010, 1'b0, 32'h0040_0014);
        end
        // One taken step from a saturated zero stays below the taken threshold
        set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        cyc();
        idle();
        look("sat_up1", 32'h0040_0010, 1'b0, 32'h0040_0014);
        set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        cyc();
        idle();
        stats("sat_up2", 4, 3);
        look("sat_up2", 32'h0040_0010, 1'b1, 32'h0040_0040);

        // Aliasing: same index, different tag
        do_reset();
        set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        cyc();
        idle();
        look("alias_lookup", 32'h0040_0050, 1'b0, 32'h0040_0054);
        set_upd(1'b1, 32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0054);
        cyc();
        idle();
        look("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
        look("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0100);

        // Same-cycle lookup and allocation on one index: no bypass
        do_reset();
        set_upd(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0080, 1'b0, 32'h0040_0024);
        look("nobypass_same", 32'h0040_0020, 1'b0, 32'h0040_0024);
        cyc();
        idle();
        look("nobypass_next", 32'h0040_0020, 1'b1, 32'h0040_0080);

        // Clear beats a same-cycle update
        set_upd(1'b1, 32'h0040_0030, 1'b1, 32'h0040_0090, 1'b0, 32'h0040_0034);
        clear = 1'b1;
        cyc();
        idle();
        look("clear_old", 32'h0040_0020, 1'b0, 32'h0040_0024);
        look("clear_upd", 32'h0040_0030, 1'b0, 32'h0040_0034);

        // Reset asserted during an update discards it
        set_upd(1'b1, 32'h0040_0070, 1'b1, 32'h0040_00a0, 1'b0, 32'h0040_0074);
        cyc();
        set_upd(1'b1, 32'h0040_0090, 1'b1, 32'h0040_00b0, 1'b0, 32'h0040_0094);
        #1;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        idle();
        model_reset();
        look("midrst_a", 32'h0040_0070, 1'b0, 32'h0040_0074);
        look("midrst_b", 32'h0040_0090, 1'b0, 32'h0040_0094);
        stats("midrst", 0, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            bit          v, t, pt, clr, exp_t, mt;
            logic [31:0] ipc, upc, tgt, ptgt, exp_tgt, mtgt;
            ipc = 32'h0040_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 2) * 32'h40);
            upc = 32'h0040_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 2) * 32'h40);
            tgt = 32'h0040_1000 + 32'($urandom_range(0, 3) * 4);
            v   = ($urandom_range(0, 3) != 0);
            t   = $urandom_range(0, 1) == 1;
            model_lookup(upc, mt, mtgt);
            if ($urandom_range(0, 3) != 0) begin
                pt = mt; ptgt = mtgt;
            end else begin
                pt = $urandom_range(0, 1) == 1;
                ptgt = 32'h0040_1000 + 32'($urandom_range(0, 3) * 4);
            end
            clr = !v && ($urandom_range(0, 39) == 0);

            set_upd(v, upc, t, tgt, pt, ptgt);
            clear = clr;
            if_pc = ipc;
            #1;
            model_lookup(ipc, exp_t, exp_tgt);
            check("rnd.pred_taken", 32'(pred_taken), 32'(exp_t));
            check("rnd.pred_target", pred_target, exp_tgt);
            check("rnd.mispredict", 32'(mispredict), 32'(model_misp(v, t, tgt, pt, ptgt)));
            if (model_misp(v, t, tgt, pt, ptgt))
                check("rnd.correct_pc", correct_pc, t ? tgt : upc + 32'd4);
            stats("rnd", m_hits, m_miss);
            model_update(clr, v, upc, t, tgt, pt, ptgt);
            cyc();
        end
        idle();
        #1;
        stats("rnd_final", m_hits, m_miss);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
